// File: rtl/periodo_pkg.sv
// Shared definitions for the period measurement controller: FSM state encoding and default widths.
package periodo_pkg;

    localparam int CNT_W_DEF       = 32;
    localparam int TIMEOUT_CYC_DEF = 50_000_000;
    localparam int AVG_LOG2_DEF    = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        MEASURE = 2'd2
    } estado_t;

    // Adds one without ever wrapping past the all-ones value.
    function automatic logic [CNT_W_DEF-1:0] inc_sat(input logic [CNT_W_DEF-1:0] v);
        return (v == '1) ? v : v + CNT_W_DEF'(1);
    endfunction

endpackage

// File: rtl/contador_sat.sv
// Saturating up-counter with synchronous clear and a terminal-count compare flag.
module contador_sat #(
    parameter int           W  = 32,
    parameter logic [W-1:0] TC = '1
) (
    input  logic         clock_FPGA,
    input  logic         reset,
    input  logic         clr,
    output logic [W-1:0] cuenta,
    output logic         fin
);

    always_ff @(posedge clock_FPGA) begin
        if (!reset) begin
            cuenta <= '0;
        end else if (clr) begin
            cuenta <= '0;
        end else if (cuenta != '1) begin
            cuenta <= cuenta + W'(1);
        end
    end

    assign fin = (cuenta == TC);

endmodule

// File: rtl/controlador_periodo.sv
// Measures clock_FPGA cycles between consecutive rising-edge pulses, single-shot or continuous, with edge timeout.
// Optional averaging of 2^AVG_LOG2 periods per result when PERIOD_AVG_EN is defined.
//
// state   | meaning
// IDLE    | waiting for start
// ARMED   | waiting for the opening edge
// MEASURE | counting cycles until the closing edge
module controlador_periodo
    import periodo_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int AVG_LOG2    = AVG_LOG2_DEF
) (
    input  logic             clock_FPGA,
    input  logic             reset,
    input  logic             start,
    input  logic             modo_continuo,
    input  logic             flanco_pos_onda_cuad,
    output logic [CNT_W-1:0] periodo,
    output logic             periodo_valido,
    output logic             ocupado,
    output logic             timeout_err
);

    // The counter holds (elapsed - 1) when sampled, so the terminal value is one below the timeout.
    localparam logic [CNT_W-1:0] TC = CNT_W'(TIMEOUT_CYC - 1);

    estado_t          estado, estado_sig;
    logic             cnt_clr;
    logic [CNT_W-1:0] cuenta;
    logic             hit;
    logic [CNT_W-1:0] medida;
    logic             cerrar;
    logic             fin_grupo;
    logic             publicar;
    logic [CNT_W-1:0] valor_pub;
    logic             err_set;
    logic             err_clr;

    contador_sat #(
        .W  (CNT_W),
        .TC (TC)
    ) u_contador (
        .clock_FPGA (clock_FPGA),
        .reset      (reset),
        .clr        (cnt_clr),
        .cuenta     (cuenta),
        .fin        (hit)
    );

    assign medida = (cuenta == '1) ? cuenta : cuenta + CNT_W'(1);

`ifdef PERIOD_AVG_EN
    localparam int ACC_W = CNT_W + AVG_LOG2;

    logic [ACC_W-1:0]    acc, acc_sum;
    logic [AVG_LOG2-1:0] grp;

    assign acc_sum   = acc + ACC_W'(medida);
    assign fin_grupo = &grp;
    assign publicar  = cerrar && fin_grupo;
    assign valor_pub = acc_sum[ACC_W-1:AVG_LOG2];

    // Partial groups only survive while measuring; timeout, reset or a new arm discards them.
    always_ff @(posedge clock_FPGA) begin
        if (!reset) begin
            acc <= '0;
            grp <= '0;
        end else if (estado != MEASURE) begin
            acc <= '0;
            grp <= '0;
        end else if (cerrar) begin
            if (fin_grupo) begin
                acc <= '0;
                grp <= '0;
            end else begin
                acc <= acc_sum;
                grp <= grp + AVG_LOG2'(1);
            end
        end
    end
`else
    assign fin_grupo = 1'b1;
    assign publicar  = cerrar;
    assign valor_pub = medida;
`endif

    always_comb begin
        estado_sig = estado;
        cnt_clr    = 1'b0;
        cerrar     = 1'b0;
        err_set    = 1'b0;
        err_clr    = 1'b0;
        case (estado)
            IDLE: begin
                cnt_clr = 1'b1;
                if (start) begin
                    estado_sig = ARMED;
                    err_clr    = 1'b1;
                end
            end
            ARMED: begin
                if (flanco_pos_onda_cuad) begin
                    estado_sig = MEASURE;
                    cnt_clr    = 1'b1;
                end else if (hit) begin
                    estado_sig = IDLE;
                    err_set    = 1'b1;
                end
            end
            MEASURE: begin
                // The closing edge doubles as the opening edge of the next period.
                if (flanco_pos_onda_cuad) begin
                    cnt_clr = 1'b1;
                    cerrar  = 1'b1;
                    if (!modo_continuo && fin_grupo) begin
                        estado_sig = IDLE;
                    end
                end else if (hit) begin
                    estado_sig = IDLE;
                    err_set    = 1'b1;
                end
            end
            default: begin
                estado_sig = IDLE;
                cnt_clr    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock_FPGA) begin
        if (!reset) begin
            estado         <= IDLE;
            periodo        <= '0;
            periodo_valido <= 1'b0;
            ocupado        <= 1'b0;
            timeout_err    <= 1'b0;
        end else begin
            estado         <= estado_sig;
            periodo_valido <= publicar;
            ocupado        <= (estado_sig != IDLE);
            if (publicar) begin
                periodo <= valor_pub;
            end
            if (err_set) begin
                timeout_err <= 1'b1;
            end else if (err_clr) begin
                timeout_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_controlador_periodo.sv
// Bench for controlador_periodo: directed scenarios plus random traffic against a timestamp-based reference model.
module tb_controlador_periodo;

    localparam int CNT_W    = 16;
    localparam int TOUT     = 100;
    localparam int AVG_LOG2 = 2;

    logic             clock_FPGA = 1'b0;
    logic             reset;
    logic             start;
    logic             modo_continuo;
    logic             flanco_pos_onda_cuad;
    logic [CNT_W-1:0] periodo;
    logic             periodo_valido;
    logic             ocupado;
    logic             timeout_err;

    always #5 clock_FPGA = ~clock_FPGA;

    controlador_periodo #(
        .CNT_W       (CNT_W),
        .TIMEOUT_CYC (TOUT),
        .AVG_LOG2    (AVG_LOG2)
    ) dut (
        .clock_FPGA           (clock_FPGA),
        .reset                (reset),
        .start                (start),
        .modo_continuo        (modo_continuo),
        .flanco_pos_onda_cuad (flanco_pos_onda_cuad),
        .periodo              (periodo),
        .periodo_valido       (periodo_valido),
        .ocupado              (ocupado),
        .timeout_err          (timeout_err)
    );

    int n_vec    = 0;
    int n_err    = 0;
    int cyc      = 0;
    int n_strobe = 0;

    // Reference model: timestamps of the last arm/edge, list of periods in the current group.
    bit m_armed, m_meas;
    int t_ref;
    int e_periodo;
    bit e_valid, e_err;
    int grupo[$];

    task automatic comprobar(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic modelo(input bit rst, input bit st, input bit md, input bit fl);
        int p;
        int suma;
        e_valid = 1'b0;
        if (!rst) begin
            m_armed = 0; m_meas = 0; e_periodo = 0; e_err = 0;
            grupo.delete();
        end else if (m_armed) begin
            if (fl) begin
                m_armed = 0; m_meas = 1; t_ref = cyc;
            end else if (cyc - t_ref >= TOUT) begin
                m_armed = 0; e_err = 1;
            end
        end else if (m_meas) begin
            if (fl) begin
                p = cyc - t_ref;
                if (p > 65535) p = 65535;
                t_ref = cyc;
`ifdef PERIOD_AVG_EN
                grupo.push_back(p);
                if (grupo.size() == (1 << AVG_LOG2)) begin
                    suma = 0;
                    foreach (grupo[k]) suma += grupo[k];
                    e_periodo = suma >> AVG_LOG2;
                    e_valid = 1;
                    grupo.delete();
                    if (!md) m_meas = 0;
                end
`else
                suma = p;
                e_periodo = suma;
                e_valid = 1;
                if (!md) m_meas = 0;
`endif
            end else if (cyc - t_ref >= TOUT) begin
                m_meas = 0; e_err = 1;
                grupo.delete();
            end
        end else if (st) begin
            m_armed = 1; t_ref = cyc; e_err = 0;
        end
    endtask

    task automatic ciclo(input bit rst, input bit st, input bit md, input bit fl);
        logic [15:0] ep;
        reset = rst; start = st; modo_continuo = md; flanco_pos_onda_cuad = fl;
        @(posedge clock_FPGA);
        cyc++;
        modelo(rst, st, md, fl);
        #1;
        ep = e_periodo[15:0];
        comprobar("salidas", {13'd0, periodo, periodo_valido, ocupado, timeout_err},
                  {13'd0, ep, e_valid, m_armed | m_meas, e_err});
        if (periodo_valido) n_strobe++;
    endtask

    task automatic espera(input int n, input bit md);
        repeat (n) ciclo(1, 0, md, 0);
    endtask

    initial begin
        bit md_r;
        int base;

        ciclo(0, 0, 0, 0);
        ciclo(0, 0, 0, 0);
        comprobar("rst_periodo", periodo, 0);
        comprobar("rst_ocupado", ocupado, 0);
        espera(3, 0);

`ifndef PERIOD_AVG_EN
        // single shot, edges 20 cycles apart
        ciclo(1, 1, 0, 0);
        espera(9, 0);
        ciclo(1, 0, 0, 1);
        espera(19, 0);
        ciclo(1, 0, 0, 1);
        comprobar("t1_periodo", periodo, 20);
        comprobar("t1_valido", periodo_valido, 1);
        ciclo(1, 0, 0, 0);
        comprobar("t1_ocupado", ocupado, 0);

        // continuous, period 17, four edges
        ciclo(1, 1, 1, 0);
        espera(2, 1);
        base = n_strobe;
        for (int i = 0; i < 4; i++) begin
            ciclo(1, 0, 1, 1);
            if (i < 3) espera(16, 1);
        end
        comprobar("t2_strobes", n_strobe - base, 3);
        comprobar("t2_periodo", periodo, 17);
        comprobar("t2_ocupado", ocupado, 1);
        espera(16, 0);
        ciclo(1, 0, 0, 1);
        ciclo(1, 0, 0, 0);
        comprobar("t2_fin", ocupado, 0);

        // timeout
        ciclo(1, 1, 0, 0);
        espera(99, 0);
        comprobar("t3_antes", timeout_err, 0);
        ciclo(1, 0, 0, 0);
        comprobar("t3_err", timeout_err, 1);
        comprobar("t3_ocupado", ocupado, 0);
        comprobar("t3_periodo", periodo, 17);
        ciclo(1, 1, 0, 0);
        comprobar("t3_clr", timeout_err, 0);
        espera(100, 0);

        // reset mid-measurement
        ciclo(1, 1, 0, 0);
        ciclo(1, 0, 0, 1);
        espera(15, 0);
        ciclo(0, 0, 0, 0);
        comprobar("t4_periodo", periodo, 0);
        comprobar("t4_ocupado", ocupado, 0);
        espera(24, 0);
        base = n_strobe;
        ciclo(1, 0, 0, 1);
        espera(3, 0);
        comprobar("t4_sin_strobe", n_strobe - base, 0);

        // start with coincident edge, then edge exactly on the timeout cycle
        ciclo(1, 1, 0, 1);
        espera(11, 0);
        ciclo(1, 0, 0, 1);
        espera(11, 0);
        ciclo(1, 0, 0, 1);
        comprobar("t5_periodo", periodo, 12);
        ciclo(1, 1, 0, 0);
        ciclo(1, 0, 0, 1);
        espera(99, 0);
        ciclo(1, 0, 0, 1);
        comprobar("t5_borde", periodo, 100);
        comprobar("t5_err", timeout_err, 0);
        espera(2, 0);
`else
        // averaging of periods 10, 11, 12, 14
        ciclo(1, 1, 1, 0);
        ciclo(1, 0, 1, 1);
        base = n_strobe;
        espera(9, 1);  ciclo(1, 0, 1, 1);
        espera(10, 1); ciclo(1, 0, 1, 1);
        espera(11, 1); ciclo(1, 0, 1, 1);
        espera(13, 0); ciclo(1, 0, 0, 1);
        comprobar("t6_periodo", periodo, 11);
        comprobar("t6_strobes", n_strobe - base, 1);
        ciclo(1, 0, 0, 0);
        comprobar("t6_ocupado", ocupado, 0);
`endif

        md_r = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 63) == 0) md_r = ~md_r;
            ciclo($urandom_range(0, 399) != 0, $urandom_range(0, 11) == 0,
                  md_r, $urandom_range(0, 27) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
